// File: rtl/fib_accum_pkg.sv
// Shared types and default parameters for the paired-accumulator loop engine.
package fib_accum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 11;
    localparam int DEF_BOUND  = 300;
    localparam int DEF_MODE_W = 2;
    localparam int DEF_STEP_W = 16;

endpackage

// File: rtl/fib_accum_if.sv
// Control/status bundle of the accumulator engine: master drives run control,
// slave (the engine) returns accumulators, step count and status flags.
interface fib_accum_if
    import fib_accum_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int MODE_W = DEF_MODE_W,
    parameter int STEP_W = DEF_STEP_W
) ();

    logic              start;
    logic [MODE_W-1:0] mode;
    logic              hold;
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y;
    logic [WIDTH-1:0]  i;
    logic [WIDTH-1:0]  j;
    logic [STEP_W-1:0] steps;
    logic              busy;
    logic              done;
    logic              ovf;
    logic              inv_fail;

    modport master (
        output start, mode, hold,
        input  x, y, i, j, steps, busy, done, ovf, inv_fail
    );

    modport slave (
        input  start, mode, hold,
        output x, y, i, j, steps, busy, done, ovf, inv_fail
    );

endinterface

// File: rtl/fib_accum_step.sv
// Combinational next-value datapath: one loop iteration of x, y, i, j plus an
// overflow flag raised when any result no longer fits in WIDTH bits.
module fib_accum_step
    import fib_accum_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int MODE_W = DEF_MODE_W
) (
    input  logic [WIDTH-1:0]  i_x,
    input  logic [WIDTH-1:0]  i_y,
    input  logic [WIDTH-1:0]  i_i,
    input  logic [WIDTH-1:0]  i_j,
    input  logic [MODE_W-1:0] i_mode,
    output logic [WIDTH-1:0]  o_x,
    output logic [WIDTH-1:0]  o_y,
    output logic [WIDTH-1:0]  o_i,
    output logic [WIDTH-1:0]  o_j,
    output logic              o_ovf
);

    // Two guard bits: j + y + 1 + mode can exceed 2**(WIDTH+1) for large
    // operands, so one carry bit alone could wrap and hide an overflow.
    localparam int EW = WIDTH + 2;

    logic [EW-1:0] w_x;
    logic [EW-1:0] w_y;
    logic [EW-1:0] w_i;
    logic [EW-1:0] w_j;

    assign w_x = EW'(i_x) + EW'(1);
    assign w_y = EW'(i_y) + EW'(1);
    assign w_i = EW'(i_i) + EW'(i_x) + EW'(1);
    assign w_j = EW'(i_j) + EW'(i_y) + EW'(i_mode) + EW'(1);

    assign o_ovf = |{w_x[EW-1:WIDTH], w_y[EW-1:WIDTH],
                     w_i[EW-1:WIDTH], w_j[EW-1:WIDTH]};

    assign o_x = w_x[WIDTH-1:0];
    assign o_y = w_y[WIDTH-1:0];
    assign o_i = w_i[WIDTH-1:0];
    assign o_j = w_j[WIDTH-1:0];

endmodule

// File: rtl/fib_accum_engine.sv
// Bounded-loop accumulator engine: FSM, accumulator registers, saturating step
// counter, sticky overflow flag and on-line j >= i invariant monitor.
module fib_accum_engine
    import fib_accum_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int BOUND  = DEF_BOUND,
    parameter int MODE_W = DEF_MODE_W,
    parameter int STEP_W = DEF_STEP_W
) (
    input logic         clk,
    input logic         rst,
    fib_accum_if.slave  io_bus
);

    localparam logic [1:0]        ST_IDLE   = IDLE;
    localparam logic [1:0]        ST_RUN    = RUN;
    localparam logic [1:0]        ST_DONE   = DONE;
    localparam logic [WIDTH:0]    BOUND_EXT = (WIDTH + 1)'(BOUND);
    localparam logic [STEP_W-1:0] STEPS_MAX = '1;

    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_x;
    logic [WIDTH-1:0]  r_y;
    logic [WIDTH-1:0]  r_i;
    logic [WIDTH-1:0]  r_j;
    logic [STEP_W-1:0] r_steps;
    logic [MODE_W-1:0] r_mode_q;
    logic              r_ovf;
    logic              r_inv_fail;

    logic [WIDTH-1:0]  w_x_n;
    logic [WIDTH-1:0]  w_y_n;
    logic [WIDTH-1:0]  w_i_n;
    logic [WIDTH-1:0]  w_j_n;
    logic              w_ovf_n;
    logic              w_guard;

    fib_accum_step #(
        .WIDTH  (WIDTH),
        .MODE_W (MODE_W)
    ) u_step (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_i    (r_i),
        .i_j    (r_j),
        .i_mode (r_mode_q),
        .o_x    (w_x_n),
        .o_y    (w_y_n),
        .o_i    (w_i_n),
        .o_j    (w_j_n),
        .o_ovf  (w_ovf_n)
    );

    assign w_guard = {1'b0, r_j} < BOUND_EXT;

    // Run control and one loop step per enabled cycle; hold freezes all of RUN.
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values and the update order inside the block is irrelevant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_steps    <= '0;
            r_mode_q   <= '0;
            r_ovf      <= 1'b0;
            r_inv_fail <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!io_bus.hold) begin
                        if (!w_guard) begin
                            r_state <= ST_DONE;
                        end else if (w_ovf_n) begin
                            // Overflow: nothing commits, accumulators keep the last good values.
                            r_ovf   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_x        <= w_x_n;
                            r_y        <= w_y_n;
                            r_i        <= w_i_n;
                            r_j        <= w_j_n;
                            r_inv_fail <= r_inv_fail | (w_j_n < w_i_n);
                            if (r_steps != STEPS_MAX) begin
                                r_steps <= r_steps + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // IDLE, DONE (and any stray encoding) accept start regardless of hold.
                    if (io_bus.start) begin
                        r_x        <= '0;
                        r_y        <= '0;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_steps    <= '0;
                        r_ovf      <= 1'b0;
                        r_inv_fail <= 1'b0;
                        r_mode_q   <= io_bus.mode;
                        r_state    <= ST_RUN;
                    end
                end
            endcase
        end
    end

    assign io_bus.x        = r_x;
    assign io_bus.y        = r_y;
    assign io_bus.i        = r_i;
    assign io_bus.j        = r_j;
    assign io_bus.steps    = r_steps;
    assign io_bus.busy     = (r_state == ST_RUN);
    assign io_bus.done     = (r_state == ST_DONE);
    assign io_bus.ovf      = r_ovf;
    assign io_bus.inv_fail = r_inv_fail;

endmodule

// File: tb/tb_fib_accum_engine.sv
// Bench for fib_accum_engine: a default instance (WIDTH=11, BOUND=300) and a
// narrow instance (WIDTH=8, BOUND=255), each tracked every cycle against an
// integer reference model through a scoreboard queue, plus scenario checks.
module tb_fib_accum_engine;
    import fib_accum_pkg::*;

    localparam int W0 = DEF_WIDTH;
    localparam int B0 = DEF_BOUND;
    localparam int W1 = 8;
    localparam int B1 = 255;
    localparam int MW = DEF_MODE_W;
    localparam int SW = DEF_STEP_W;

    typedef logic [31:0] u32;

    typedef struct {
        state_e st;
        u32     x;
        u32     y;
        u32     i;
        u32     j;
        u32     steps;
        u32     mode_q;
        logic   ovf;
        logic   inv;
    } snap_t;

    logic  clk = 1'b0;
    logic  rst;
    int    n_err = 0;
    int    n_chk = 0;
    int    cyc   = 0;
    snap_t m0;
    snap_t m1;
    snap_t q0[$];
    snap_t q1[$];

    fib_accum_if #(.WIDTH(W0), .MODE_W(MW), .STEP_W(SW)) bus0 ();
    fib_accum_if #(.WIDTH(W1), .MODE_W(MW), .STEP_W(SW)) bus1 ();

    fib_accum_engine #(.WIDTH(W0), .BOUND(B0), .MODE_W(MW), .STEP_W(SW)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus0)
    );

    fib_accum_engine #(.WIDTH(W1), .BOUND(B1), .MODE_W(MW), .STEP_W(SW)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus1)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    function automatic snap_t zero_snap();
        snap_t z;
        z.st = IDLE; z.x = 0; z.y = 0; z.i = 0; z.j = 0;
        z.steps = 0; z.mode_q = 0; z.ovf = 1'b0; z.inv = 1'b0;
        return z;
    endfunction

    // Reference behaviour of one clock edge, in plain 32-bit integer arithmetic.
    function automatic snap_t model_next(snap_t s, int width, int bound, logic r,
                                         logic st_in, u32 mode, logic hold);
        snap_t n;
        u32    lim;
        u32    nx, ny, ni, nj;
        n   = s;
        lim = u32'(1) << width;
        if (r) begin
            n = zero_snap();
        end else if (s.st != RUN) begin
            if (st_in) begin
                n        = zero_snap();
                n.mode_q = mode;
                n.st     = RUN;
            end
        end else if (!hold) begin
            if (s.j >= u32'(bound)) begin
                n.st = DONE;
            end else begin
                nx = s.x + 1;
                ny = s.y + 1;
                ni = s.i + s.x + 1;
                nj = s.j + s.y + 1 + s.mode_q;
                if (nx >= lim || ny >= lim || ni >= lim || nj >= lim) begin
                    n.ovf = 1'b1;
                    n.st  = DONE;
                end else begin
                    n.x = nx; n.y = ny; n.i = ni; n.j = nj;
                    n.steps = (s.steps == 32'd65535) ? s.steps : s.steps + 1;
                    n.inv   = s.inv | (nj < ni);
                end
            end
        end
        return n;
    endfunction

    // One clock: push model predictions, let the edge pass, pop and compare both DUTs.
    task automatic tick();
        snap_t e;
        q0.push_back(model_next(m0, W0, B0, rst, bus0.start, u32'(bus0.mode), bus0.hold));
        q1.push_back(model_next(m1, W1, B1, rst, bus1.start, u32'(bus1.mode), bus1.hold));
        @(posedge clk);
        #1;
        cyc++;
        e  = q0.pop_front();
        m0 = e;
        n_chk++;
        if (u32'(bus0.x) !== e.x || u32'(bus0.y) !== e.y || u32'(bus0.i) !== e.i ||
            u32'(bus0.j) !== e.j || u32'(bus0.steps) !== e.steps ||
            {bus0.busy, bus0.done, bus0.ovf, bus0.inv_fail} !==
            {e.st == RUN, e.st == DONE, e.ovf, e.inv}) begin
            n_err++;
            $display("FAIL sb0 cyc=%0d got x=%0d y=%0d i=%0d j=%0d steps=%0d busy=%b done=%b ovf=%b inv=%b exp x=%0d y=%0d i=%0d j=%0d steps=%0d busy=%b done=%b ovf=%b inv=%b",
                     cyc, bus0.x, bus0.y, bus0.i, bus0.j, bus0.steps, bus0.busy, bus0.done, bus0.ovf, bus0.inv_fail,
                     e.x, e.y, e.i, e.j, e.steps, e.st == RUN, e.st == DONE, e.ovf, e.inv);
        end
        e  = q1.pop_front();
        m1 = e;
        n_chk++;
        if (u32'(bus1.x) !== e.x || u32'(bus1.y) !== e.y || u32'(bus1.i) !== e.i ||
            u32'(bus1.j) !== e.j || u32'(bus1.steps) !== e.steps ||
            {bus1.busy, bus1.done, bus1.ovf, bus1.inv_fail} !==
            {e.st == RUN, e.st == DONE, e.ovf, e.inv}) begin
            n_err++;
            $display("FAIL sb1 cyc=%0d got x=%0d y=%0d i=%0d j=%0d steps=%0d busy=%b done=%b ovf=%b inv=%b exp x=%0d y=%0d i=%0d j=%0d steps=%0d busy=%b done=%b ovf=%b inv=%b",
                     cyc, bus1.x, bus1.y, bus1.i, bus1.j, bus1.steps, bus1.busy, bus1.done, bus1.ovf, bus1.inv_fail,
                     e.x, e.y, e.i, e.j, e.steps, e.st == RUN, e.st == DONE, e.ovf, e.inv);
        end
    endtask

    // Tick until the selected DUT shows done; n counts ticks taken.
    task automatic wait_done(input int sel, input int max_ticks, output int n);
        logic d;
        n = 0;
        d = 1'b0;
        while (!d && n < max_ticks) begin
            tick();
            n++;
            d = (sel == 0) ? bus0.done : bus1.done;
        end
        n_chk++;
        if (!d) begin
            n_err++;
            $display("FAIL done_timeout dut%0d got done=0 after %0d ticks, required done=1", sel, n);
        end
    endtask

    task automatic start0(input logic [MW-1:0] md);
        bus0.mode  = md;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_chk++;
        if ({bus0.x, bus0.y, bus0.i, bus0.j, bus0.steps, bus0.busy, bus0.done, bus0.ovf, bus0.inv_fail} !== '0) begin
            n_err++;
            $display("FAIL reset0 got x=%0d j=%0d steps=%0d busy=%b done=%b, required all zero",
                     bus0.x, bus0.j, bus0.steps, bus0.busy, bus0.done);
        end
        n_chk++;
        if ({bus1.x, bus1.j, bus1.steps, bus1.busy, bus1.done, bus1.ovf} !== '0) begin
            n_err++;
            $display("FAIL reset1 got x=%0d j=%0d steps=%0d busy=%b done=%b ovf=%b, required all zero",
                     bus1.x, bus1.j, bus1.steps, bus1.busy, bus1.done, bus1.ovf);
        end
    endtask

    task automatic test_mode0();
        int n;
        start0(2'd0);
        wait_done(0, 100, n);
        n_chk++;
        if (n != 25) begin
            n_err++;
            $display("FAIL mode0_latency got %0d ticks after start, required 25", n);
        end
        n_chk++;
        if ({bus0.x, bus0.y, bus0.i, bus0.j, bus0.steps} !== {11'd24, 11'd24, 11'd300, 11'd300, 16'd24} ||
            {bus0.ovf, bus0.inv_fail, bus0.done} !== 3'b001) begin
            n_err++;
            $display("FAIL mode0_final got x=%0d y=%0d i=%0d j=%0d steps=%0d ovf=%b inv=%b done=%b, required 24 24 300 300 24 0 0 1",
                     bus0.x, bus0.y, bus0.i, bus0.j, bus0.steps, bus0.ovf, bus0.inv_fail, bus0.done);
        end
    endtask

    task automatic test_mode1();
        int n;
        start0(2'd1);
        wait_done(0, 100, n);
        n_chk++;
        if ({bus0.x, bus0.i, bus0.j, bus0.steps} !== {11'd24, 11'd300, 11'd324, 16'd24} ||
            {bus0.ovf, bus0.inv_fail, bus0.done} !== 3'b001) begin
            n_err++;
            $display("FAIL mode1_final got x=%0d i=%0d j=%0d steps=%0d ovf=%b inv=%b done=%b, required 24 300 324 24 0 0 1",
                     bus0.x, bus0.i, bus0.j, bus0.steps, bus0.ovf, bus0.inv_fail, bus0.done);
        end
    endtask

    task automatic test_overflow();
        int n;
        bus1.mode  = 2'd3;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        wait_done(1, 100, n);
        n_chk++;
        if (n != 20) begin
            n_err++;
            $display("FAIL ovf_latency got %0d ticks after start, required 20", n);
        end
        n_chk++;
        if ({bus1.x, bus1.i, bus1.j} !== {8'd19, 8'd190, 8'd247} || bus1.steps !== 16'd19 ||
            {bus1.ovf, bus1.done, bus1.busy} !== 3'b110) begin
            n_err++;
            $display("FAIL ovf_final got x=%0d i=%0d j=%0d steps=%0d ovf=%b done=%b busy=%b, required 19 190 247 19 1 1 0",
                     bus1.x, bus1.i, bus1.j, bus1.steps, bus1.ovf, bus1.done, bus1.busy);
        end
    endtask

    task automatic test_hold();
        int n;
        start0(2'd0);
        for (int k = 0; k < 7; k++) tick();
        bus0.hold = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        n_chk++;
        if ({bus0.x, bus0.i, bus0.j, bus0.steps, bus0.busy} !== {11'd7, 11'd28, 11'd28, 16'd7, 1'b1}) begin
            n_err++;
            $display("FAIL hold_frozen got x=%0d i=%0d j=%0d steps=%0d busy=%b, required 7 28 28 7 1",
                     bus0.x, bus0.i, bus0.j, bus0.steps, bus0.busy);
        end
        bus0.hold = 1'b0;
        wait_done(0, 100, n);
        n_chk++;
        if (n + 12 != 30) begin
            n_err++;
            $display("FAIL hold_latency got %0d ticks after start, required 30", n + 12);
        end
        n_chk++;
        if ({bus0.x, bus0.i, bus0.j, bus0.steps} !== {11'd24, 11'd300, 11'd300, 16'd24}) begin
            n_err++;
            $display("FAIL hold_final got x=%0d i=%0d j=%0d steps=%0d, required 24 300 300 24",
                     bus0.x, bus0.i, bus0.j, bus0.steps);
        end
    endtask

    task automatic test_restart();
        bus0.mode  = 2'd2;
        bus1.mode  = 2'd2;
        bus0.start = 1'b1;
        bus1.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        n_chk++;
        if ({bus1.busy, bus1.done, bus1.ovf, bus1.inv_fail} !== 4'b1000 || bus1.steps !== 16'd0 ||
            bus1.j !== 8'd0 || bus0.busy !== 1'b1 || bus0.x !== 11'd0) begin
            n_err++;
            $display("FAIL restart_clear got busy=%b done=%b ovf=%b steps=%0d j=%0d busy0=%b x0=%0d, required 1 0 0 0 0 1 0",
                     bus1.busy, bus1.done, bus1.ovf, bus1.steps, bus1.j, bus0.busy, bus0.x);
        end
        tick();
        n_chk++;
        if (bus0.j !== 11'd3 || bus1.j !== 8'd3 || bus0.x !== 11'd1 || bus1.steps !== 16'd1) begin
            n_err++;
            $display("FAIL restart_first got j0=%0d j1=%0d x0=%0d steps1=%0d, required 3 3 1 1",
                     bus0.j, bus1.j, bus0.x, bus1.steps);
        end
    endtask

    task automatic test_reset_mid_run();
        // dut0 is one step into a mode-2 run; a start with mode 0 must change nothing.
        for (int k = 0; k < 3; k++) tick();
        bus0.mode  = 2'd0;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        n_chk++;
        if ({bus0.x, bus0.j, bus0.steps, bus0.busy} !== {11'd10, 11'd75, 16'd10, 1'b1}) begin
            n_err++;
            $display("FAIL start_in_run got x=%0d j=%0d steps=%0d busy=%b, required 10 75 10 1",
                     bus0.x, bus0.j, bus0.steps, bus0.busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if ({bus0.x, bus0.y, bus0.i, bus0.j, bus0.steps, bus0.busy, bus0.done, bus0.ovf, bus0.inv_fail} !== '0) begin
            n_err++;
            $display("FAIL mid_run_reset got x=%0d j=%0d steps=%0d busy=%b done=%b, required all zero",
                     bus0.x, bus0.j, bus0.steps, bus0.busy, bus0.done);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus0.start = 1'b0;
        bus0.mode  = '0;
        bus0.hold  = 1'b0;
        bus1.start = 1'b0;
        bus1.mode  = '0;
        bus1.hold  = 1'b0;
        m0 = zero_snap();
        m1 = zero_snap();
        @(negedge clk);
        test_reset();
        test_mode0();
        test_mode1();
        test_overflow();
        test_hold();
        test_restart();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
